// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA pixel path
// (fetch stage, VGA driver, pixel-mapping logic).
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef logic [23:0] rgb_t;

  localparam int DEF_IMG_W      = 256;
  localparam int DEF_IMG_H      = 256;
  localparam int DEF_FIFO_DEPTH = 8;

  function automatic rgb_t grey_to_rgb(input logic [7:0] g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush and occupancy count.
// The head entry is always presented at the output; valid means it is real.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  // Writes to a full FIFO and pops from an empty one are dropped.
  assign push_ok = push && (cnt != CW'(DEPTH));
  assign pop_ok  = pop && (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Per-frame raster prefetch from data memory port B into a small pixel FIFO,
// presenting grey pixels as RGB to the VGA driver via valid/ready.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int          IMG_W      = DEF_IMG_W,
  parameter int          IMG_H      = DEF_IMG_H,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         mem_rd_en,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_rdata,
  output logic         pix_valid,
  input  logic         pix_ready,
  output rgb_t         pix_color,
  output logic         pix_last,
  output logic         busy,
  output fetch_state_t state
);

  // Handshake: a pixel transfers on every rising edge where
  // pix_valid && pix_ready; pix_valid never depends on pix_ready.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    x;
  logic [7:0]    y;
  logic [7:0]    ix;
  logic [7:0]    iy;
  logic          i_last;
  logic          issue;
  logic          do_issue;
  logic          credit_ok;
  logic [31:0]   issue_addr;
  logic          issue_last_q;
  logic          ret_q;
  logic          ret_last_q;
  logic [CW-1:0] fifo_count;
  logic [8:0]    head;
  logic          fifo_valid;
  logic          rdata_unused;

  assign rdata_unused = ^mem_rdata[31:8];

  // A restart issues pixel (0,0) directly, regardless of the old counters.
  assign ix     = start ? 8'd0 : x;
  assign iy     = start ? 8'd0 : y;
  assign i_last = (ix == 8'(IMG_W - 1)) && (iy == 8'(IMG_H - 1));

  // Credit: a return landing this cycle is not yet in the registered count,
  // and a strobe this cycle blocks the next issue, so at most one read is
  // ever outstanding and the FIFO cannot overflow.
  assign credit_ok  = (int'(fifo_count) + int'(ret_q)) < FIFO_DEPTH;
  assign issue      = (state == FETCH) && !mem_rd_en && credit_ok;
  assign do_issue   = start || issue;
  assign issue_addr = BASE_ADDR + ((32'(iy) * 32'(IMG_W) + 32'(ix)) << 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= BASE_ADDR;
      x            <= '0;
      y            <= '0;
      issue_last_q <= 1'b0;
      ret_q        <= 1'b0;
      ret_last_q   <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      ret_q      <= start ? 1'b0 : mem_rd_en;
      ret_last_q <= issue_last_q;

      if (do_issue) begin
        mem_rd_en    <= 1'b1;
        mem_addr     <= issue_addr;
        issue_last_q <= i_last;
        if (ix == 8'(IMG_W - 1)) begin
          x <= '0;
          y <= iy + 8'd1;
        end else begin
          x <= ix + 8'd1;
          y <= iy;
        end
      end

      if (start) begin
        state <= i_last ? DRAIN : FETCH;
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          FETCH: begin
            if (issue && i_last) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if ((fifo_count == '0) && !ret_q && !mem_rd_en) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (start),
    .push      (ret_q),
    .push_data ({ret_last_q, mem_rdata[7:0]}),
    .pop       (fifo_valid && pix_ready),
    .head      (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign pix_valid = fifo_valid;
  assign pix_color = grey_to_rgb(head[7:0]);
  assign pix_last  = head[8];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: three geometries, memory model returning
// address>>2 in the low byte, scoreboard of expected pixels per frame.
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  logic         clk;
  logic         reset_n;
  logic [2:0]   start_v;
  logic [2:0]   rd_en_v;
  logic [2:0]   valid_v;
  logic [2:0]   ready_v;
  logic [2:0]   last_v;
  logic [2:0]   busy_v;
  logic [31:0]  addr_v  [3];
  logic [31:0]  rdata_v [3];
  rgb_t         color_v [3];
  fetch_state_t state_v [3];

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;
  int last_cnt = 0;
  int last_pop_idx = 0;
  int last_pop_cyc = 0;
  int busy_fall_cyc = 0;
  logic [31:0] exp_addr = 32'h0;
  logic        hold_pend = 1'b0;
  rgb_t        hold_color;
  logic        hold_last;
  logic        prev_busy = 1'b0;
  logic        t6_done = 1'b0;
  logic [24:0] exp_q[$];

  vga_pixel_fetch u_big (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]),
    .mem_rd_en(rd_en_v[0]), .mem_addr(addr_v[0]), .mem_rdata(rdata_v[0]),
    .pix_valid(valid_v[0]), .pix_ready(ready_v[0]), .pix_color(color_v[0]),
    .pix_last(last_v[0]), .busy(busy_v[0]), .state(state_v[0])
  );

  vga_pixel_fetch #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(32'h100)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]),
    .mem_rd_en(rd_en_v[1]), .mem_addr(addr_v[1]), .mem_rdata(rdata_v[1]),
    .pix_valid(valid_v[1]), .pix_ready(ready_v[1]), .pix_color(color_v[1]),
    .pix_last(last_v[1]), .busy(busy_v[1]), .state(state_v[1])
  );

  vga_pixel_fetch #(.IMG_W(16), .IMG_H(8), .BASE_ADDR(32'h2040)) u_mid (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]),
    .mem_rd_en(rd_en_v[2]), .mem_addr(addr_v[2]), .mem_rdata(rdata_v[2]),
    .pix_valid(valid_v[2]), .pix_ready(ready_v[2]), .pix_color(color_v[2]),
    .pix_last(last_v[2]), .busy(busy_v[2]), .state(state_v[2])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] base_of(input int i);
    case (i)
      1:       return 32'h100;
      2:       return 32'h2040;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int pix_of(input int i);
    case (i)
      1:       return 4 * 2;
      2:       return 16 * 8;
      default: return 256 * 256;
    endcase
  endfunction

  // ---------------- memory model ----------------
  always @(posedge clk) begin : mem_model
    logic [23:0] junk;
    for (int i = 0; i < 3; i++) begin
      junk = 24'($urandom);
      rdata_v[i] <= rd_en_v[i] ? {junk, addr_v[i][9:2]} : $urandom;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [24:0] e;
    cyc++;
    if (rd_en_v[sel]) begin
      check("rd_addr", addr_v[sel], exp_addr);
      exp_addr = exp_addr + 32'd4;
      rd_cnt++;
    end
    if (hold_pend && valid_v[sel]) begin
      check("hold_color", color_v[sel], hold_color);
      check("hold_last", last_v[sel], hold_last);
    end
    hold_pend  = valid_v[sel] && !ready_v[sel];
    hold_color = color_v[sel];
    hold_last  = last_v[sel];
    if (valid_v[sel] && ready_v[sel]) begin
      pop_cnt++;
      if (last_v[sel]) begin
        last_cnt++;
        last_pop_idx = pop_cnt;
        last_pop_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        check("extra_pix", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pix_color", color_v[sel], 32'(e[23:0]));
        check("pix_last", last_v[sel], 32'(e[24]));
      end
    end
    if (prev_busy && !busy_v[sel]) busy_fall_cyc = cyc;
    prev_busy = busy_v[sel];
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int i);
    logic [7:0] g;
    int n;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    sel = i;
    exp_q.delete();
    n = pix_of(i);
    for (int k = 0; k < n; k++) begin
      g = 8'((base_of(i) >> 2) + 32'(k));
      exp_q.push_back({(k == n - 1), g, g, g});
    end
    exp_addr  = base_of(i);
    rd_cnt    = 0;
    pop_cnt   = 0;
    last_cnt  = 0;
    last_pop_idx = 0;
    hold_pend = 1'b0;
    prev_busy = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int max_cyc, input string tag);
    int c = 0;
    while (pop_cnt < n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(pop_cnt >= n), 32'd1);
  endtask

  task automatic wait_busy_low(input int i, input int max_cyc, input string tag);
    int c = 0;
    while (busy_v[i] && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(busy_v[i]), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    check({tag, "_rd_en"}, rd_en_v[i], 32'd0);
    check({tag, "_addr"}, addr_v[i], base_of(i));
    check({tag, "_valid"}, valid_v[i], 32'd0);
    check({tag, "_color"}, color_v[i], 32'd0);
    check({tag, "_last"}, last_v[i], 32'd0);
    check({tag, "_busy"}, busy_v[i], 32'd0);
    check({tag, "_state"}, 32'(state_v[i]), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd_before;
    reset_n = 1'b0;
    start_v = '0;
    ready_v = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_vals(i, "rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency of the first pixel, consumer always ready.
    ready_v[0] = 1'b1;
    pulse_start(0);
    @(negedge clk);
    check("c1_busy", busy_v[0], 32'd1);
    check("c1_rd_en", rd_en_v[0], 32'd1);
    check("c1_valid", valid_v[0], 32'd0);
    @(negedge clk);
    check("c2_rd_en", rd_en_v[0], 32'd0);
    check("c2_valid", valid_v[0], 32'd0);
    @(negedge clk);
    check("c3_valid", valid_v[0], 32'd1);
    check("c3_color", color_v[0], 32'h000000);
    wait_pops(12, 100, "t1_pops");

    // Back-pressure: credit limits outstanding reads to FIFO_DEPTH.
    @(negedge clk);
    ready_v[0] = 1'b0;
    pulse_start(0);
    repeat (40) @(negedge clk);
    check("bp_reads", 32'(rd_cnt), 32'd8);
    check("bp_valid", valid_v[0], 32'd1);
    ready_v[0] = 1'b1;
    wait_pops(30, 200, "bp_resume");

    // Restart with a read in flight.
    begin
      int c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!rd_en_v[0] && c < 20);
      check("rs_rd_seen", rd_en_v[0], 32'd1);
    end
    pulse_start(0);
    @(negedge clk);
    check("rs_flush_valid", valid_v[0], 32'd0);
    check("rs_rd_en", rd_en_v[0], 32'd1);
    @(negedge clk);
    check("rs_discard_valid", valid_v[0], 32'd0);
    wait_pops(10, 100, "rs_pops");

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals(0, "arst");
    @(negedge clk);
    reset_n = 1'b1;
    rd_before = rd_cnt;
    repeat (6) @(negedge clk);
    check("arst_no_rd", 32'(rd_cnt), 32'(rd_before));
    check("arst_idle", 32'(state_v[0]), 32'(IDLE));
    pulse_start(0);
    wait_pops(10, 100, "arst_refetch");
    ready_v[0] = 1'b0;

    // Small 4x2 frame, consumer always ready.
    @(negedge clk);
    ready_v[1] = 1'b1;
    pulse_start(1);
    wait_busy_low(1, 200, "sm_busy_low");
    check("sm_pops", 32'(pop_cnt), 32'd8);
    check("sm_last_cnt", 32'(last_cnt), 32'd1);
    check("sm_last_idx", 32'(last_pop_idx), 32'd8);
    check("sm_q_empty", 32'(exp_q.size()), 32'd0);
    check("sm_busy_delay", 32'(busy_fall_cyc - last_pop_cyc), 32'd2);
    repeat (10) @(negedge clk);
    check("sm_no_more_rd", 32'(rd_cnt), 32'd8);
    check("sm_idle", 32'(state_v[1]), 32'(IDLE));

    // 16x8 frame with a random consumer.
    @(negedge clk);
    fork
      begin
        while (!t6_done) begin
          ready_v[2] = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        ready_v[2] = 1'b0;
      end
    join_none
    pulse_start(2);
    wait_busy_low(2, 5000, "rnd_busy_low");
    t6_done = 1'b1;
    check("rnd_pops", 32'(pop_cnt), 32'd128);
    check("rnd_reads", 32'(rd_cnt), 32'd128);
    check("rnd_last_cnt", 32'(last_cnt), 32'd1);
    check("rnd_last_idx", 32'(last_pop_idx), 32'd128);
    check("rnd_q_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Prefetch stage between the equalized-image data memory and the VGA driver. Once per frame it walks the image in raster order, issues synchronous reads on the second memory port, and buffers returned pixels in a small FIFO. The driver pops pixels through a valid/ready handshake, so memory latency is decoupled from pixel timing. Each stored 8-bit grey value is expanded to 24-bit RGB.

## Interface
- IMG_W, 256, pixels per image row (power of two, ≤256)
- IMG_H, 256, image rows (≤256)
- BASE_ADDR, 32'h0, byte address of pixel (0,0); one pixel per 32-bit word
- FIFO_DEPTH, 8, pixel FIFO entries (power of two, ≥4)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse at frame start; begins or restarts a frame fetch
- mem_rd_en  out  1  read strobe to data memory port B
- mem_addr  out  32  byte address, word aligned
- mem_rdata  in  32  read data, valid exactly one cycle after mem_rd_en
- pix_valid  out  1  FIFO head holds a pixel
- pix_ready  in  1  consumer accepts the head pixel this cycle
- pix_color  out  24  {g,g,g} with g = stored word[7:0]
- pix_last  out  1  head pixel is (IMG_W-1, IMG_H-1)
- busy  out  1  frame fetch in progress or FIFO not empty

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE: `start` → FETCH; counters x=y=0.
  - FETCH → DRAIN: after the read for the last pixel issues.
  - DRAIN → IDLE: FIFO empty and no read in flight.
- Issue rule in FETCH: assert mem_rd_en when `count + inflight < FIFO_DEPTH`.
  - `inflight` is 0 or 1.
  - This credit rule makes overflow impossible.
- Address: `BASE_ADDR + ((y*IMG_W + x) << 2)`.
  - x increments on each issue and wraps to 0 at IMG_W-1, incrementing y.
  - Last pixel is x=IMG_W-1, y=IMG_H-1.
- Return: the cycle after an issue, `mem_rdata[7:0]` is written to the FIFO together with its last flag. Bits [31:8] are ignored.
- Pop: the head advances when `pix_valid && pix_ready`. `pix_ready` while empty has no effect.
- Push and pop in the same cycle: count is unchanged.
- `start` while not IDLE (restart):
  - FIFO is flushed and the in-flight return is discarded.
  - Counters reset to 0 and state goes to FETCH.
  - The first read issues the next cycle.
- `start` while in DRAIN behaves the same way.

## Timing
- Reset values: state=IDLE, mem_rd_en=0, mem_addr=BASE_ADDR, pix_valid=0, pix_color=0, pix_last=0, busy=0, count=0, inflight=0.
- Cycle 0 is `start` sampled high. The first read issues in cycle 1, is written to the FIFO at the end of cycle 2, and pix_valid=1 in cycle 3.
- With the consumer always ready, steady state is one pixel per 2 cycles minimum. The credit check uses registered count, so there is no combinational path from pix_ready to mem_rd_en.
- pix_color and pix_last are registered FIFO head outputs, stable while `pix_valid && !pix_ready`.
- busy rises the cycle after start and falls the cycle after DRAIN→IDLE.
- Reset mid-frame: all state clears asynchronously and no further mem_rd_en is issued until the next `start`.

## Structure
- Package `vga_pkg`:
  - `fetch_state_t` enum (IDLE, FETCH, DRAIN).
  - `rgb_t` (24-bit) typedef.
  - Default IMG_W/IMG_H/FIFO_DEPTH constants, shared with the VGA driver and pixel-mapping logic.
- Sub-module `sync_fifo`: parameterised width/depth, show-ahead output, synchronous flush, count output. Entry is {last, g[7:0]}.
- Top-level FSM, counters and address generation live in vga_pixel_fetch.

## Test plan
- Reset then `start`, memory model returns word = address>>2, pix_ready=1 → mem_addr 0,4,8…; first pix_valid at cycle 3 with pix_color=24'h000000; pixel 5 = 24'h050505.
- IMG_W=4, IMG_H=2, consumer ready → exactly 8 pixels, pix_last only on the 8th; busy low two cycles after the final pop; no further mem_rd_en.
- pix_ready held 0 for 40 cycles → exactly FIFO_DEPTH reads issued, count=8, no overflow; releasing ready resumes reads with correct order.
- `start` re-pulsed mid-frame with a read in flight → returned word discarded, FIFO empty next cycle, next mem_addr=BASE_ADDR, first delivered pixel is (0,0).
- reset_n asserted between clock edges mid-frame → all outputs at reset values immediately; `start` after release refetches from (0,0).
- Random pix_ready (50%) over a full 256×256 frame → 65536 pixels in raster order, data matches the memory model, single pix_last.
